// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared types, result codes and helpers for the sequential magnitude comparator
package comp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] RES_LT = 2'd0;
  localparam logic [1:0] RES_EQ = 2'd1;
  localparam logic [1:0] RES_GT = 2'd2;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/comp_slice.sv
// rtl/comp_slice.sv - combinational CHUNK-bit unsigned lt/gt compare, MSB-first cascade
module comp_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] sa,
  input  logic [CHUNK-1:0] sb,
  output logic             slt,
  output logic             sgt
);

  logic lt_v;
  logic gt_v;

  // Walk from MSB down; the first differing bit decides and masks all lower bits
  always_comb begin
    lt_v = 1'b0;
    gt_v = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (!lt_v && !gt_v) begin
        if (sa[i] && !sb[i]) begin
          gt_v = 1'b1;
        end else if (!sa[i] && sb[i]) begin
          lt_v = 1'b1;
        end
      end
    end
    slt = lt_v;
    sgt = gt_v;
  end

endmodule

// File: rtl/seq_mag_comp.sv
// rtl/seq_mag_comp.sv - multi-cycle MSB-first magnitude comparator, CHUNK bits per clock
module seq_mag_comp
  import comp_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int CHUNK  = 2,
  localparam int NSLICE = WIDTH / CHUNK,
  localparam int CW     = clog2(NSLICE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [CW-1:0]    ncyc
);

  localparam int              IW      = (NSLICE > 1) ? clog2(NSLICE) : 1;
  localparam logic [IW-1:0]   TOP_IDX = IW'(NSLICE - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [IW-1:0]    idx_q;
  logic             done_q;
  logic             lt_q;
  logic             gt_q;
  logic             eq_q;
  logic [CW-1:0]    ncyc_q;
  logic [CW-1:0]    ncyc_d;

  logic [CHUNK-1:0] sa;
  logic [CHUNK-1:0] sb;
  logic             slt;
  logic             sgt;
  logic [1:0]       res_d;

  // Select the current slice; in signed mode flip the sign bit so two's complement orders as unsigned
  always_comb begin
    sa = a_q[int'(idx_q) * CHUNK +: CHUNK];
    sb = b_q[int'(idx_q) * CHUNK +: CHUNK];
    if (sgn_q && (idx_q == TOP_IDX)) begin
      sa[CHUNK-1] = ~sa[CHUNK-1];
      sb[CHUNK-1] = ~sb[CHUNK-1];
    end
  end

  comp_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .sa (sa),
    .sb (sb),
    .slt(slt),
    .sgt(sgt)
  );

  assign res_d  = sgt ? RES_GT : (slt ? RES_LT : RES_EQ);
  assign ncyc_d = ncyc_q + CW'(1);

  // Control FSM with operand latch, slice index, registered result and cycle count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      ncyc_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sgn_q   <= sgn;
            idx_q   <= TOP_IDX;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            ncyc_q  <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          ncyc_q <= ncyc_d;
          if (sgt || slt || (idx_q == '0)) begin
            lt_q    <= (res_d == RES_LT);
            gt_q    <= (res_d == RES_GT);
            eq_q    <= (res_d == RES_EQ);
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign ncyc = ncyc_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// tb/tb_seq_mag_comp.sv - self-checking bench for seq_mag_comp against an arithmetic reference
module tb_seq_mag_comp;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // 8-bit, 2 bits per cycle
  logic       start8 = 1'b0;
  logic       sgn8   = 1'b0;
  logic [7:0] a8     = '0;
  logic [7:0] b8     = '0;
  logic       busy8, done8, lt8, gt8, eq8;
  logic [2:0] ncyc8;

  // 16-bit shared stimulus for the wide (CHUNK=16) and narrow (CHUNK=1) instances
  logic        start16 = 1'b0;
  logic        sgn16   = 1'b0;
  logic [15:0] a16     = '0;
  logic [15:0] b16     = '0;
  logic        busy_w, done_w, lt_w, gt_w, eq_w;
  logic [0:0]  ncyc_w;
  logic        busy_n, done_n, lt_n, gt_n, eq_n;
  logic [4:0]  ncyc_n;

  seq_mag_comp #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .lt(lt8), .gt(gt8), .eq(eq8), .ncyc(ncyc8)
  );

  seq_mag_comp #(.WIDTH(16), .CHUNK(16)) u_dut_w (
    .clk(clk), .rst(rst), .start(start16), .sgn(sgn16), .a(a16), .b(b16),
    .busy(busy_w), .done(done_w), .lt(lt_w), .gt(gt_w), .eq(eq_w), .ncyc(ncyc_w)
  );

  seq_mag_comp #(.WIDTH(16), .CHUNK(1)) u_dut_n (
    .clk(clk), .rst(rst), .start(start16), .sgn(sgn16), .a(a16), .b(b16),
    .busy(busy_n), .done(done_n), .lt(lt_n), .gt(gt_n), .eq(eq_n), .ncyc(ncyc_n)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: compare as integers; result packed as {lt, gt, eq}
  function automatic logic [2:0] ref_res(input logic [15:0] x, input logic [15:0] y,
                                         input logic s, input int w);
    longint vx;
    longint vy;
    vx = longint'(x);
    vy = longint'(y);
    if (s && x[w-1]) vx = vx - (64'sd1 <<< w);
    if (s && y[w-1]) vy = vy - (64'sd1 <<< w);
    return {vx < vy, vx > vy, vx == vy};
  endfunction

  // Reference: position of first differing chunk counted from the MSB, plus one
  function automatic int ref_ncyc(input logic [15:0] x, input logic [15:0] y,
                                  input int w, input int c);
    longint mask;
    int     n;
    int     sh;
    mask = (64'sd1 <<< c) - 1;
    n    = w / c;
    for (int k = 0; k < n; k++) begin
      sh = w - (k + 1) * c;
      if (((longint'(x) >> sh) & mask) != ((longint'(y) >> sh) & mask)) return k + 1;
    end
    return n;
  endfunction

  int busy_cnt;

  // Issue one 8-bit compare and return at the negedge where done is high
  task automatic run8(input logic [7:0] aa, input logic [7:0] bb, input logic s);
    int k;
    @(negedge clk);
    start8 = 1'b1; a8 = aa; b8 = bb; sgn8 = s;
    @(negedge clk);
    start8 = 1'b0;
    busy_cnt = 0;
    k = 0;
    while (!done8 && k < 40) begin
      if (busy8) busy_cnt++;
      @(negedge clk);
      k++;
    end
    if (!done8) chk("run8_timeout", 0, 1);
  endtask

  task automatic chk8(input string tag, input logic [7:0] aa, input logic [7:0] bb, input logic s);
    chk({tag, "_res"}, {lt8, gt8, eq8}, ref_res({8'h00, aa}, {8'h00, bb}, s, 8));
    chk({tag, "_ncyc"}, ncyc8, ref_ncyc({8'h00, aa}, {8'h00, bb}, 8, 2));
  endtask

  initial begin
    int          k;
    int          dsum;
    logic [15:0] x;
    logic [15:0] y;
    logic        s;
    logic [2:0]  res_w, res_n;
    int          nc_w, nc_n;
    bit          got_w, got_n;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_lt", lt8, 0);
    chk("rst_gt", gt8, 0);
    chk("rst_eq", eq8, 0);
    chk("rst_ncyc", ncyc8, 0);

    // Equal operands: full scan, result held after done
    run8(8'h5A, 8'h5A, 1'b0);
    chk("eq_busycnt", busy_cnt, 4);
    chk("eq_res", {lt8, gt8, eq8}, 3'b001);
    chk("eq_ncyc", ncyc8, 4);
    @(negedge clk);
    chk("eq_done_fall", done8, 0);
    chk("eq_hold", {lt8, gt8, eq8, ncyc8}, {3'b001, 3'd4});

    run8(8'h80, 8'h7F, 1'b0);
    chk("u80_res", {lt8, gt8, eq8}, 3'b010);
    chk("u80_ncyc", ncyc8, 1);
    run8(8'h80, 8'h7F, 1'b1);
    chk("s80_res", {lt8, gt8, eq8}, 3'b100);
    chk("s80_ncyc", ncyc8, 1);
    run8(8'h12, 8'h13, 1'b0);
    chk("u12_res", {lt8, gt8, eq8}, 3'b100);
    chk("u12_ncyc", ncyc8, 4);
    run8(8'hFF, 8'h00, 1'b1);
    chk("sFF_res", {lt8, gt8, eq8}, 3'b100);
    chk("sFF_ncyc", ncyc8, 1);

    // Reset in the second RUN cycle aborts with no done pulse
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h13; sgn8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    chk("abort_busy1", busy8, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outs", {busy8, done8, lt8, gt8, eq8, ncyc8}, 0);
    dsum = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dsum += int'(done8);
    end
    chk("abort_nodone", dsum, 0);

    // Start while busy is ignored; start on done cycle is accepted without a bubble
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h13; sgn8 = 1'b0;
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00;
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ign_done_seen", done8, 1);
    chk("ign_res", {lt8, gt8, eq8}, 3'b100);
    chk("ign_ncyc", ncyc8, 4);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h7F; sgn8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b_busy", busy8, 1);
    k = 0;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_res", {lt8, gt8, eq8}, 3'b010);
    chk("b2b_ncyc", ncyc8, 1);

    // Random 8-bit
    for (int i = 0; i < 200; i++) begin
      x = 16'($urandom_range(0, 255));
      y = ($urandom_range(0, 3) == 0) ? x : 16'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      run8(x[7:0], y[7:0], s);
      chk8("rnd8", x[7:0], y[7:0], s);
    end

    // Random 16-bit on both CHUNK=16 and CHUNK=1 instances
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ (16'h1 << $urandom_range(0, 15));
        default: y = 16'($urandom);
      endcase
      s = 1'($urandom_range(0, 1));
      @(negedge clk);
      start16 = 1'b1; a16 = x; b16 = y; sgn16 = s;
      @(negedge clk);
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = ~s;
      got_w = 1'b0; got_n = 1'b0;
      res_w = '0; res_n = '0; nc_w = 0; nc_n = 0;
      k = 0;
      while (!(got_w && got_n) && k < 40) begin
        if (done_w && !got_w) begin
          res_w = {lt_w, gt_w, eq_w}; nc_w = int'(ncyc_w); got_w = 1'b1;
        end
        if (done_n && !got_n) begin
          res_n = {lt_n, gt_n, eq_n}; nc_n = int'(ncyc_n); got_n = 1'b1;
        end
        if (!(got_w && got_n)) @(negedge clk);
        k++;
      end
      if (!(got_w && got_n)) chk("rnd16_timeout", {got_w, got_n}, 2'b11);
      chk("rnd16w_res", res_w, ref_res(x, y, s, 16));
      chk("rnd16w_ncyc", nc_w, 1);
      chk("rnd16n_res", res_n, ref_res(x, y, s, 16));
      chk("rnd16n_ncyc", nc_n, ref_ncyc(x, y, 16, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
